// File: rtl/arb2_pkg.sv
// Shared types and source encodings for the two-input round-robin stream merger.
package arb2_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_LOCK_A, ST_LOCK_B} arb2_state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the source that did not win last time wins.
module rr_pick2 (
  input  logic a_valid,
  input  logic b_valid,
  input  logic prio,
  output logic grant_a,
  output logic grant_b
);

  // prio holds the last winner (0 = A, 1 = B), so a tie goes to the other one
  assign grant_a = a_valid & (~b_valid | prio);
  assign grant_b = b_valid & (~a_valid | ~prio);

endmodule

// File: rtl/arb2_stream_merge.sv
// Round-robin merge of two valid/ready packet streams into one registered output with a source select.
module arb2_stream_merge
  import arb2_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  input  logic [W-1:0] a_data,
  input  logic         a_last,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [W-1:0] b_data,
  input  logic         b_last,
  output logic         b_ready,
  output logic         y_valid,
  output logic [W-1:0] y_data,
  output logic         y_last,
  output logic         s,
  input  logic         y_ready
);

  arb2_state_t state, state_nxt;
  logic prio;
  logic pick_a, pick_b;
  logic grant_a, grant_b;
  logic space;
  logic acc_a, acc_b, accept, acc_last;

  rr_pick2 u_pick (
    .a_valid (a_valid),
    .b_valid (b_valid),
    .prio    (prio),
    .grant_a (pick_a),
    .grant_b (pick_b)
  );

  // A lock pins the grant to its owner even while that owner is not valid
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state)
      ST_IDLE: begin
        grant_a = pick_a;
        grant_b = pick_b;
      end
      ST_LOCK_A: grant_a = a_valid;
      ST_LOCK_B: grant_b = b_valid;
      default: ;
    endcase
  end

  assign space    = ~y_valid | y_ready;
  assign a_ready  = ~rst & space & grant_a;
  assign b_ready  = ~rst & space & grant_b;
  assign acc_a    = a_valid & a_ready;
  assign acc_b    = b_valid & b_ready;
  assign accept   = acc_a | acc_b;
  assign acc_last = acc_a ? a_last : b_last;

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        ST_IDLE: begin
          if (!acc_last) state_nxt = acc_a ? ST_LOCK_A : ST_LOCK_B;
        end
        ST_LOCK_A, ST_LOCK_B: begin
          if (acc_last) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // An accept in the same cycle as a drain simply overwrites the held beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      prio    <= SRC_B;
      y_valid <= 1'b0;
      y_data  <= '0;
      y_last  <= 1'b0;
      s       <= SRC_A;
    end else begin
      state <= state_nxt;
      if (accept) begin
        y_valid <= 1'b1;
        y_data  <= acc_a ? a_data : b_data;
        y_last  <= acc_last;
        s       <= acc_b ? SRC_B : SRC_A;
        prio    <= acc_b ? SRC_B : SRC_A;
      end else if (y_valid && y_ready) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb2_stream_merge.sv
// Self-checking bench for arb2_stream_merge: directed scenarios plus randomized traffic against a packet-level model.
module tb_arb2_stream_merge;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic a_valid, a_last, a_ready;
  logic b_valid, b_last, b_ready;
  logic y_valid, y_last, s, y_ready;
  logic [W-1:0] a_data, b_data, y_data;

  int total = 0;
  int bad = 0;

  // Model: owner of an open packet (-1 none), last winner, and the held output beat
  int m_owner;
  int m_prio;
  int m_acc;
  bit m_yv;
  bit m_ylast;
  bit m_s;
  logic [W-1:0] m_ydata;

  always #5 clk = ~clk;

  arb2_stream_merge #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_last  (a_last),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_last  (b_last),
    .b_ready (b_ready),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_last  (y_last),
    .s       (s),
    .y_ready (y_ready)
  );

  // Sources must hold a pending beat unchanged until it is taken
  logic pa_pend, pb_pend;
  logic [W-1:0] pa_data, pb_data;
  logic pa_last, pb_last;
  initial begin
    pa_pend = 1'b0;
    pb_pend = 1'b0;
  end
  always @(posedge clk) begin
    if (!rst && pa_pend && (!a_valid || a_data !== pa_data || a_last !== pa_last))
      $error("[TB] protocol: source A changed a pending beat");
    if (!rst && pb_pend && (!b_valid || b_data !== pb_data || b_last !== pb_last))
      $error("[TB] protocol: source B changed a pending beat");
    pa_pend <= !rst && a_valid && !a_ready;
    pb_pend <= !rst && b_valid && !b_ready;
    pa_data <= a_data;
    pa_last <= a_last;
    pb_data <= b_data;
    pb_last <= b_last;
  end

  function automatic int pred_grant();
    if (rst) return -1;
    if (m_owner == 0) return a_valid ? 0 : -1;
    if (m_owner == 1) return b_valid ? 1 : -1;
    if (a_valid && b_valid) return 1 - m_prio;
    if (a_valid) return 0;
    if (b_valid) return 1;
    return -1;
  endfunction

  function automatic bit pred_ready(int src);
    return (pred_grant() == src) && (!m_yv || y_ready);
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_prio  = 1;
    m_acc   = -1;
    m_yv    = 1'b0;
    m_ylast = 1'b0;
    m_s     = 1'b0;
    m_ydata = '0;
  endtask

  // Advance one clock; inputs set after the previous falling edge are captured at the rising edge
  task automatic tick();
    int g;
    bit sp;
    g  = pred_grant();
    sp = !m_yv || y_ready;
    @(posedge clk);
    m_acc = -1;
    if (rst) begin
      model_reset();
    end else if (g >= 0 && sp) begin
      m_acc   = g;
      m_yv    = 1'b1;
      m_ydata = (g == 0) ? a_data : b_data;
      m_ylast = (g == 0) ? a_last : b_last;
      m_s     = (g == 1);
      m_prio  = g;
      m_owner = m_ylast ? -1 : g;
    end else if (m_yv && y_ready) begin
      m_yv = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    y_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 1'b1; a_data = 8'h5A; a_last = 1'b1;
    b_valid = 1'b1; b_data = 8'hA5; b_last = 1'b1;
    y_ready = 1'b1;
    #1;
    total++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_readies: a_ready=%b b_ready=%b required 0 0", a_ready, b_ready);
    end
    tick();
    total++;
    if (y_valid !== 1'b0 || y_data !== 8'h00 || y_last !== 1'b0 || s !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: y_valid=%b y_data=%h y_last=%b s=%b required 0 00 0 0",
               y_valid, y_data, y_last, s);
    end
    rst = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_single_beat();
    reset_dut();
    a_valid = 1'b1; a_data = 8'h3C; a_last = 1'b1;
    y_ready = 1'b1;
    #1;
    total++;
    if (a_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_ready: a_ready=%b required 1", a_ready);
    end
    tick();
    a_valid = 1'b0;
    total++;
    if (y_valid !== 1'b1 || y_data !== 8'h3C || s !== 1'b0 || y_last !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_out: y_valid=%b y_data=%h s=%b y_last=%b required 1 3c 0 1",
               y_valid, y_data, s, y_last);
    end
  endtask

  task automatic test_tie_alternation();
    logic [W-1:0] exp_seq [6];
    int ia, ib;
    exp_seq = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
    reset_dut();
    ia = 0;
    ib = 0;
    for (int k = 0; k < 6; k++) begin
      a_valid = 1'b1; a_data = 8'hA0 + W'(ia); a_last = 1'b1;
      b_valid = 1'b1; b_data = 8'hB0 + W'(ib); b_last = 1'b1;
      y_ready = 1'b1;
      #1;
      tick();
      total++;
      if (y_valid !== 1'b1 || y_data !== exp_seq[k] || s !== k[0]) begin
        bad++;
        $display("[TB] FAIL tie_beat%0d: y_valid=%b y_data=%h s=%b required 1 %h %b",
                 k, y_valid, y_data, s, exp_seq[k], k[0]);
      end
      if (k[0]) ib++; else ia++;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_packet_lock();
    logic [W-1:0] a_seq [3];
    a_seq = '{8'h10, 8'h11, 8'h12};
    reset_dut();
    b_valid = 1'b1; b_data = 8'hBB; b_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_valid = (k < 3);
      a_data  = (k < 3) ? a_seq[k] : 8'h00;
      a_last  = (k == 2);
      #1;
      total++;
      if (b_ready !== (k == 3)) begin
        bad++;
        $display("[TB] FAIL lock_b_ready%0d: b_ready=%b required %b", k, b_ready, (k == 3));
      end
      tick();
      total++;
      if (k < 3 && (y_data !== a_seq[k] || s !== 1'b0)) begin
        bad++;
        $display("[TB] FAIL lock_a_beat%0d: y_data=%h s=%b required %h 0", k, y_data, s, a_seq[k]);
      end else if (k == 3 && (y_data !== 8'hBB || s !== 1'b1)) begin
        bad++;
        $display("[TB] FAIL lock_b_beat: y_data=%h s=%b required bb 1", y_data, s);
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    reset_dut();
    a_valid = 1'b1; a_data = 8'h55; a_last = 1'b1;
    tick();
    a_valid = 1'b0;
    b_valid = 1'b1; b_data = 8'h66; b_last = 1'b1;
    y_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL bp_readies%0d: a_ready=%b b_ready=%b required 0 0", k, a_ready, b_ready);
      end
      tick();
      total++;
      if (y_valid !== 1'b1 || y_data !== 8'h55 || s !== 1'b0) begin
        bad++;
        $display("[TB] FAIL bp_hold%0d: y_valid=%b y_data=%h s=%b required 1 55 0", k, y_valid, y_data, s);
      end
    end
    y_ready = 1'b1;
    #1;
    total++;
    if (b_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_release_ready: b_ready=%b required 1", b_ready);
    end
    tick();
    b_valid = 1'b0;
    total++;
    if (y_valid !== 1'b1 || y_data !== 8'h66 || s !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_replace: y_valid=%b y_data=%h s=%b required 1 66 1", y_valid, y_data, s);
    end
    tick();
    total++;
    if (y_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_drain: y_valid=%b required 0", y_valid);
    end
  endtask

  task automatic test_idle_lock();
    reset_dut();
    a_valid = 1'b1; a_data = 8'h21; a_last = 1'b0;
    b_valid = 1'b1; b_data = 8'h77; b_last = 1'b1;
    tick();
    a_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (b_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL idle_lock%0d: b_ready=%b required 0", k, b_ready);
      end
      tick();
    end
    a_valid = 1'b1; a_data = 8'h22; a_last = 1'b1;
    #1;
    tick();
    total++;
    if (y_data !== 8'h22 || s !== 1'b0 || y_last !== 1'b1) begin
      bad++;
      $display("[TB] FAIL idle_lock_last: y_data=%h s=%b y_last=%b required 22 0 1", y_data, s, y_last);
    end
    a_valid = 1'b0;
    #1;
    total++;
    if (b_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL idle_unlock_ready: b_ready=%b required 1", b_ready);
    end
    tick();
    b_valid = 1'b0;
    total++;
    if (y_data !== 8'h77 || s !== 1'b1) begin
      bad++;
      $display("[TB] FAIL idle_unlock_beat: y_data=%h s=%b required 77 1", y_data, s);
    end
  endtask

  task automatic test_reset_mid_packet();
    reset_dut();
    b_valid = 1'b1; b_data = 8'h31; b_last = 1'b0;
    tick();
    rst = 1'b1;
    b_data = 8'h32;
    a_valid = 1'b1; a_data = 8'h41; a_last = 1'b1;
    #1;
    total++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrst_readies: a_ready=%b b_ready=%b required 0 0", a_ready, b_ready);
    end
    tick();
    rst = 1'b0;
    total++;
    if (y_valid !== 1'b0 || y_data !== 8'h00 || y_last !== 1'b0 || s !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrst_outputs: y_valid=%b y_data=%h y_last=%b s=%b required 0 00 0 0",
               y_valid, y_data, y_last, s);
    end
    #1;
    total++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrst_tie: a_ready=%b b_ready=%b required 1 0", a_ready, b_ready);
    end
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_random();
    reset_dut();
    for (int k = 0; k < 600; k++) begin
      if (m_acc == 0) a_valid = 1'b0;
      if (m_acc == 1) b_valid = 1'b0;
      if (!a_valid && $urandom_range(0, 2) != 0) begin
        a_valid = 1'b1;
        a_data  = W'($urandom);
        a_last  = ($urandom_range(0, 2) == 0);
      end
      if (!b_valid && $urandom_range(0, 2) != 0) begin
        b_valid = 1'b1;
        b_data  = W'($urandom);
        b_last  = ($urandom_range(0, 2) == 0);
      end
      y_ready = ($urandom_range(0, 3) != 0);
      #1;
      total++;
      if (a_ready !== pred_ready(0) || b_ready !== pred_ready(1)) begin
        bad++;
        $display("[TB] FAIL rand_ready%0d: a_ready=%b b_ready=%b required %b %b",
                 k, a_ready, b_ready, pred_ready(0), pred_ready(1));
      end
      tick();
      total++;
      if (y_valid !== m_yv || (m_yv && (y_data !== m_ydata || s !== m_s || y_last !== m_ylast))) begin
        bad++;
        $display("[TB] FAIL rand_out%0d: y_valid=%b y_data=%h s=%b y_last=%b required %b %h %b %b",
                 k, y_valid, y_data, s, y_last, m_yv, m_ydata, m_s, m_ylast);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_data = '0; a_last = 1'b0;
    b_valid = 1'b0; b_data = '0; b_last = 1'b0;
    y_ready = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_beat();
    test_tie_alternation();
    test_packet_lock();
    test_backpressure();
    test_idle_lock();
    test_reset_mid_packet();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
